// File: rtl/hough_pkg.sv
// hough_pkg: shared defaults, FSM state type, address-width helper and peak record
// for the Hough vote accumulator.
package hough_pkg;
  localparam int RHOS_DEF = 64;
  localparam int THETAS_DEF = 180;
  localparam int RHO_BITS_DEF = 16;
  localparam int THETA_BITS_DEF = 8;
  localparam int ACCUM_BITS_DEF = 8;
  localparam int THRESHOLD_DEF = 8;
  typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN, SCAN} state_types;
  function automatic int addr_w(input int rhos, input int thetas);
    return $clog2(rhos * thetas);
  endfunction
  typedef struct packed {
    logic [$clog2(RHOS_DEF)-1:0] rho;
    logic [THETA_BITS_DEF-1:0]   theta;
    logic [ACCUM_BITS_DEF-1:0]   count;
  } peak_t;
endpackage

// File: rtl/accum_bram.sv
// accum_bram: single-clock simple dual-port RAM with a registered one-cycle read;
// read-during-write returns the old word, hazards are handled by the caller.
module accum_bram #(
  parameter int DEPTH = 11520,
  parameter int DW = 8,
  parameter int AW = 14
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/hough_accumulator.sv
// hough_accumulator: pops (rho, theta) votes into a RHOS x THETAS counter RAM, then scans
// and clears it, streaming peaks. HOUGH_ACCUM_SATURATE_EN makes counters saturate instead of wrap.
module hough_accumulator
  import hough_pkg::*;
#(
  parameter int RHOS = RHOS_DEF,
  parameter int THETAS = THETAS_DEF,
  parameter int RHO_BITS = RHO_BITS_DEF,
  parameter int THETA_BITS = THETA_BITS_DEF,
  parameter int ACCUM_BITS = ACCUM_BITS_DEF,
  parameter int THRESHOLD = THRESHOLD_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [RHO_BITS-1:0]     i_rho_dout,
  input  logic                    i_rho_empty,
  output logic                    o_rho_rd_en,
  input  logic [THETA_BITS-1:0]   i_theta_dout,
  input  logic                    i_theta_empty,
  output logic                    o_theta_rd_en,
  input  logic                    i_frame_done,
  input  logic                    i_peak_full,
  output logic                    o_peak_wr_en,
  output logic [$clog2(RHOS)-1:0] o_peak_rho,
  output logic [THETA_BITS-1:0]   o_peak_theta,
  output logic [ACCUM_BITS-1:0]   o_peak_count,
  output logic                    o_scan_done,
  output logic                    o_busy,
  output logic [15:0]             o_drop_count
);
  localparam int N = RHOS * THETAS;
  localparam int AW = addr_w(RHOS, THETAS);
  localparam int RW = $clog2(RHOS);
  state_types r_state;
  logic [AW-1:0] r_scan_addr, r_e_addr, r_b_addr, r_last_addr;
  logic [RW-1:0] r_s_rho, r_e_rho, r_peak_rho;
  logic [THETA_BITS-1:0] r_s_theta, r_e_theta, r_peak_theta;
  logic [ACCUM_BITS-1:0] r_last_data, r_peak_count;
  logic r_scan_more, r_e_valid, r_b_valid, r_last_valid, r_pend, r_scan_done;
  logic [15:0] r_drop;
  logic w_vote_st, w_in_range, w_pop, w_stall, w_peak_wr, w_we;
  logic [AW-1:0] w_vote_addr, w_raddr, w_waddr;
  logic [ACCUM_BITS-1:0] w_rdata, w_old, w_new, w_wdata;

  // A pending peak blocks pops so a pop and a peak write never share a cycle.
  always_comb begin
    w_vote_st = r_state == ACCUM || r_state == DRAIN;
    w_in_range = i_rho_dout < RHO_BITS'(RHOS) && i_theta_dout < THETA_BITS'(THETAS);
    w_pop = w_vote_st && !i_rho_empty && !i_theta_empty && !r_pend;
    w_vote_addr = AW'(i_rho_dout[RW-1:0]) * AW'(THETAS) + AW'(i_theta_dout);
    w_stall = r_pend && i_peak_full;
    w_peak_wr = r_pend && !i_peak_full;
    w_old = r_last_valid && r_last_addr == r_b_addr ? r_last_data : w_rdata;
    w_we = r_state == CLEAR || (r_state == SCAN ? r_e_valid && !w_stall : r_b_valid);
    w_waddr = r_state == CLEAR ? r_scan_addr : r_state == SCAN ? r_e_addr : r_b_addr;
    w_wdata = w_vote_st ? w_new : '0;
    w_raddr = r_state != SCAN ? w_vote_addr : w_stall ? r_e_addr : r_scan_addr;
  end

`ifdef HOUGH_ACCUM_SATURATE_EN
  assign w_new = &w_old ? w_old : w_old + ACCUM_BITS'(1);
`else
  assign w_new = w_old + ACCUM_BITS'(1);
`endif

  accum_bram #(.DEPTH(N), .DW(ACCUM_BITS), .AW(AW)) u_bram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // While stalled the examined cell is re-read and not cleared, so nothing advances.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= CLEAR;
      r_scan_addr <= '0;
      r_s_rho <= '0;
      r_s_theta <= '0;
      r_scan_more <= 1'b0;
      r_e_valid <= 1'b0;
      r_e_addr <= '0;
      r_e_rho <= '0;
      r_e_theta <= '0;
      r_b_valid <= 1'b0;
      r_b_addr <= '0;
      r_last_valid <= 1'b0;
      r_last_addr <= '0;
      r_last_data <= '0;
      r_pend <= 1'b0;
      r_peak_rho <= '0;
      r_peak_theta <= '0;
      r_peak_count <= '0;
      r_scan_done <= 1'b0;
      r_drop <= '0;
    end else begin
      r_last_valid <= w_we;
      r_last_addr <= w_waddr;
      r_last_data <= w_wdata;
      r_b_valid <= w_pop && w_in_range;
      r_b_addr <= w_vote_addr;
      if (w_pop && !w_in_range) r_drop <= r_drop + 16'd1;
      r_scan_done <= 1'b0;
      if (w_peak_wr) r_pend <= 1'b0;
      case (r_state)
        CLEAR: begin
          r_scan_addr <= r_scan_addr + AW'(1);
          if (r_scan_addr == AW'(N - 1)) r_state <= ACCUM;
        end
        ACCUM: if (i_frame_done) r_state <= DRAIN;
        DRAIN: begin
          if (i_rho_empty && i_theta_empty && !r_b_valid) begin
            r_state <= SCAN;
            r_scan_addr <= '0;
            r_s_rho <= '0;
            r_s_theta <= '0;
            r_scan_more <= 1'b1;
            r_e_valid <= 1'b0;
          end
        end
        SCAN: begin
          if (!w_stall) begin
            r_e_valid <= r_scan_more;
            r_e_addr <= r_scan_addr;
            r_e_rho <= r_s_rho;
            r_e_theta <= r_s_theta;
            if (r_scan_more) begin
              r_scan_addr <= r_scan_addr + AW'(1);
              r_s_theta <= r_s_theta == THETA_BITS'(THETAS - 1) ? '0 : r_s_theta + THETA_BITS'(1);
              r_s_rho <= r_s_theta == THETA_BITS'(THETAS - 1) ? r_s_rho + RW'(1) : r_s_rho;
              r_scan_more <= r_scan_addr != AW'(N - 1);
            end
            if (r_e_valid && w_rdata >= ACCUM_BITS'(THRESHOLD)) begin
              r_pend <= 1'b1;
              r_peak_rho <= r_e_rho;
              r_peak_theta <= r_e_theta;
              r_peak_count <= w_rdata;
            end
            if (r_e_valid && r_e_addr == AW'(N - 1)) begin
              r_state <= ACCUM;
              r_scan_done <= 1'b1;
              r_e_valid <= 1'b0;
            end
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign o_rho_rd_en = w_pop;
  assign o_theta_rd_en = w_pop;
  assign o_peak_wr_en = w_peak_wr;
  assign o_peak_rho = r_peak_rho;
  assign o_peak_theta = r_peak_theta;
  assign o_peak_count = r_peak_count;
  assign o_scan_done = r_scan_done;
  assign o_busy = r_state == CLEAR || r_state == SCAN;
  assign o_drop_count = r_drop;
endmodule

// File: tb/tb_hough_accumulator.sv
// tb_hough_accumulator: directed frames against FWFT FIFO models with a peak sink and
// hand-computed peak lists; HOUGH_ACCUM_SATURATE_EN selects the saturation expectation.
module tb_hough_accumulator;
  localparam int N = 64 * 180;
`ifdef HOUGH_ACCUM_SATURATE_EN
  localparam int SAT_EXP = 255;
`else
  localparam int SAT_EXP = 44;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [15:0] rho_dout = '0;
  logic rho_empty = 1'b1;
  logic rho_rd_en;
  logic [7:0] theta_dout = '0;
  logic theta_empty = 1'b1;
  logic theta_rd_en;
  logic frame_done = 1'b0;
  logic peak_full = 1'b0;
  logic peak_wr_en;
  logic [5:0] peak_rho;
  logic [7:0] peak_theta;
  logic [7:0] peak_count;
  logic scan_done;
  logic busy;
  logic [15:0] drop_count;
  logic [15:0] rho_q[$];
  logic [7:0] theta_q[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic pop_pend = 1'b0;
  int done_cnt = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hough_accumulator dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rho_dout    (rho_dout),
    .i_rho_empty   (rho_empty),
    .o_rho_rd_en   (rho_rd_en),
    .i_theta_dout  (theta_dout),
    .i_theta_empty (theta_empty),
    .o_theta_rd_en (theta_rd_en),
    .i_frame_done  (frame_done),
    .i_peak_full   (peak_full),
    .o_peak_wr_en  (peak_wr_en),
    .o_peak_rho    (peak_rho),
    .o_peak_theta  (peak_theta),
    .o_peak_count  (peak_count),
    .o_scan_done   (scan_done),
    .o_busy        (busy),
    .o_drop_count  (drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int r, input int t, input int c);
    return {10'd0, 6'(r), 8'(t), 8'(c)};
  endfunction

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input int r, input int t, input int n);
    repeat (n) begin
      rho_q.push_back(16'(r));
      theta_q.push_back(8'(t));
    end
  endtask

  task automatic count_clear(input string tag);
    int cnt = 0;
    while (busy && cnt < 12000) begin
      cnt++;
      tick();
    end
    chk(tag, cnt, N);
  endtask

  task automatic send_frame();
    tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic wait_scan();
    int n = 0;
    while (!busy && n < 400) begin
      tick();
      n++;
    end
    chk("scan_entry", busy, 1);
  endtask

  task automatic end_frame(input string tag, input int start);
    int n = 0;
    while (done_cnt == start && n < 15000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk({tag, "_scan_done"}, done_cnt - start, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_npeaks"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) chk({tag, "_peak"}, i < got_q.size() ? got_q[i] : 32'hFFFFFFFF, exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // FWFT FIFO models and peak sink; a pop seen before a rising edge is retired at the next falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (pop_pend) begin
        void'(rho_q.pop_front());
        void'(theta_q.pop_front());
      end
      #1;
      rho_empty = rho_q.size() == 0;
      theta_empty = theta_q.size() == 0;
      rho_dout = rho_empty ? 16'd0 : rho_q[0];
      theta_dout = theta_empty ? 8'd0 : theta_q[0];
      #2;
      pop_pend = rho_rd_en;
      if (rho_rd_en || theta_rd_en) begin
        chk("rd_en_pair", rho_rd_en, theta_rd_en);
        chk("pop_with_wr", peak_wr_en, 0);
      end
      if (peak_wr_en) begin
        chk("wr_while_full", peak_full, 0);
        got_q.push_back({10'd0, peak_rho, peak_theta, peak_count});
      end
      if (scan_done) done_cnt++;
    end
  end

  initial begin
    int start;
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_rd_en", {rho_rd_en, theta_rd_en}, 0);
    chk("rst_wr_en", peak_wr_en, 0);
    chk("rst_peak", {peak_rho, peak_theta, peak_count}, 0);
    chk("rst_scan_done", scan_done, 0);
    chk("rst_busy", busy, 1);
    chk("rst_drop", drop_count, 0);
    rst_n = 1'b1;
    count_clear("clear_cycles");
    chk("idle_rd_en", rho_rd_en, 0);
    chk("idle_wr_en", peak_wr_en, 0);
    push(5, 90, 10);
    push(3, 0, 8);
    push(3, 1, 7);
    push(63, 179, 9);
    exp_q = '{mk(3, 0, 8), mk(5, 90, 10), mk(63, 179, 9)};
    start = done_cnt;
    send_frame();
    end_frame("f1", start);
    for (int f = 0; f < 2; f++) begin
      push(1, 1, 8);
      push(1, 2, 12);
      push(1, 3, 9);
      push(1, 4, 20);
      exp_q = '{mk(1, 1, 8), mk(1, 2, 12), mk(1, 3, 9), mk(1, 4, 20)};
      start = done_cnt;
      send_frame();
      if (f == 0) begin
        wait_scan();
        repeat (180) tick();
        peak_full = 1'b1;
        repeat (20) tick();
        peak_full = 1'b0;
      end
      end_frame(f == 0 ? "stall" : "repeat", start);
    end
    push(7, 7, 9);
    send_frame();
    wait_scan();
    repeat (50) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", rho_rd_en, 0);
    chk("mid_rst_wr_en", peak_wr_en, 0);
    chk("mid_rst_peak", {peak_rho, peak_theta, peak_count}, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_scan_done", scan_done, 0);
    tick();
    rst_n = 1'b1;
    count_clear("reclear_cycles");
    push(64, 0, 1);
    push(0, 180, 1);
    push(9, 9, 8);
    push(0, 0, 300);
    exp_q = '{mk(0, 0, SAT_EXP), mk(9, 9, 8)};
    start = done_cnt;
    send_frame();
    end_frame("post_rst", start);
    chk("drop_count", drop_count, 2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/hough_accumulator.md
# hough_accumulator

Vote-accumulation stage directly downstream of the rho calculator. It pops paired (rho index, theta index) votes from two first-word-fall-through FIFOs and increments a RHOS×THETAS counter array with one vote per cycle. On a frame-done pulse it drains all pending votes, then scans the array. It streams every cell at or above THRESHOLD into a peak FIFO and clears each cell as it is read, leaving the array ready for the next frame.

## Interface
- RHOS, 64: number of rho bins; valid rho index 0..RHOS-1
- THETAS, 180: number of theta bins; valid theta index 0..THETAS-1
- RHO_BITS, 16: width of incoming rho word
- THETA_BITS, 8: width of theta index
- ACCUM_BITS, 8: counter width per cell
- THRESHOLD, 8: minimum count reported as a peak
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rho_dout  in  RHO_BITS  FWFT head of rho FIFO, unsigned bin index
- rho_empty  in  1  rho FIFO empty
- rho_rd_en  out  1  pop rho FIFO
- theta_dout  in  THETA_BITS  FWFT head of theta FIFO
- theta_empty  in  1  theta FIFO empty
- theta_rd_en  out  1  pop theta FIFO
- frame_done  in  1  one-cycle pulse: no further votes for this frame
- peak_full  in  1  peak FIFO full
- peak_wr_en  out  1  write peak FIFO
- peak_rho  out  clog2(RHOS)  rho bin of peak
- peak_theta  out  THETA_BITS  theta bin of peak
- peak_count  out  ACCUM_BITS  vote count of peak
- scan_done  out  1  one-cycle pulse after the last cell is scanned
- busy  out  1  high in CLEAR and SCAN
- drop_count  out  16  out-of-range votes discarded since reset, wraps

## Operation
- States: CLEAR, ACCUM, DRAIN, SCAN. Reset enters CLEAR.
- CLEAR writes zero to addresses 0..RHOS*THETAS-1, one per cycle, then enters ACCUM.
- ACCUM pops both FIFOs in the same cycle only when both are non-empty. rho_rd_en and theta_rd_en are always equal.
- Cell address is rho*THETAS + theta.
- A vote with rho >= RHOS or theta >= THETAS is popped, not written, and increments drop_count.
- Increment pipeline:
  - Stage A (pop cycle): issue synchronous read; register the address and a valid bit.
  - Stage B: new = old+1, written at the end of the cycle.
- Forwarding: if the stage-B address equals the previous cycle's write address, use the registered last-write value instead of the RAM output. Back-to-back votes to the same cell must both count.
- frame_done is latched whether it arrives in ACCUM or DRAIN. From ACCUM it moves to DRAIN.
- DRAIN keeps popping and moves to SCAN when both FIFOs are empty and stage A/B are idle.
- A frame_done received in CLEAR or SCAN is ignored.
- SCAN reads addresses 0..N-1 with one-cycle RAM latency.
  - Each read cell is written to zero in the same cycle its value is examined.
  - Emit {rho, theta, count} when count >= THRESHOLD.
  - If peak_full is high when an emit is due, hold the address, data and write pointer until it drops. No peak may be lost or duplicated.
- After the last cell, pulse scan_done and return to ACCUM. No CLEAR is needed between frames.

## Timing
- Reset values: rho_rd_en=0, theta_rd_en=0, peak_wr_en=0, peak_rho/theta/count=0, scan_done=0, busy=1, drop_count=0.
- Reset deassertion mid-frame restarts in CLEAR and discards all pending state.
- CLEAR lasts exactly RHOS*THETAS cycles. busy falls on the first ACCUM cycle.
- Throughput in ACCUM is 1 vote/cycle. Write latency is 2 cycles from pop.
- DRAIN-to-SCAN transition takes at most 2 cycles after both FIFOs are empty.
- SCAN with no stalls lasts RHOS*THETAS+1 cycles. The first peak_wr_en can come 2 cycles after SCAN entry.
- peak_wr_en is never asserted while peak_full=1.
- Only one of pop and peak write is ever active in a given cycle.

## Configuration
- HOUGH_ACCUM_SATURATE_EN
  - Defined: an increment of a cell at 2^ACCUM_BITS-1 keeps it there.
  - Undefined: the counter wraps to 0.
  - Forwarding applies the same rule either way.

## Structure
- Shared package hough_pkg holds:
  - state_types enum {CLEAR, ACCUM, DRAIN, SCAN}
  - the address-width function clog2(RHOS*THETAS)
  - the peak record typedef {rho, theta, count}
- Sub-module accum_bram: single-clock simple dual-port RAM, depth RHOS*THETAS, width ACCUM_BITS, synchronous one-cycle read, write-first not required because forwarding covers hazards.

## Test plan
- Reset, then idle FIFOs: busy high for 11520 cycles then low, no pops, all outputs at reset values.
- Push 10 identical votes (rho=5, theta=90) back-to-back, then frame_done: exactly one peak (5, 90, 10), then scan_done.
- Votes (3,0)×8, (3,1)×7, (63,179)×9, then frame_done: peaks (3,0,8) and (63,179,9) only, in address order.
- Hold peak_full high for 20 cycles during SCAN with 4 peaks present: same 4 peaks emitted in order, none duplicated. A second identical frame yields identical peaks, proving clear-on-read.
- Vote rho=64 and theta=180: both dropped, drop_count=2, no peak. Then 300 votes to (0,0): count 255 with HOUGH_ACCUM_SATURATE_EN, 44 without.
- Assert reset mid-SCAN: outputs return to reset values immediately. The block re-enters CLEAR and the next frame reports only its own votes.
